gen_pulse_train: RTL
====================

GEN_PULSE_TRAIN -- requirements
Module: gen_pulse_train

Interface
REQ-001 The block SHALL have parameter PULSE_POL, default 1: active level of the generated pulse (1 = high pulse, 0 = low pulse).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16: width of the pulse-width and gap-width fields and their counters.
REQ-003 The block SHALL have parameter NUM_WIDTH, default 8: width of the pulse-count field and its counter.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request to start a pulse train.
- i_stop  input  1  abort request.
- iv_pulse_width  input  COUNT_WIDTH  active width, in clk cycles.
- iv_gap_width  input  COUNT_WIDTH  inactive gap between pulses, in clk cycles.
- iv_pulse_num  input  NUM_WIDTH  number of pulses in the train.
- o_pulse  output  1  generated pulse; a registered output.
- o_busy  output  1  high while a train is in progress.
- o_done  output  1  one-cycle strobe marking normal completion.

Function
REQ-005 The block SHALL implement an FSM with states S_IDLE, S_PULSE and S_GAP.
REQ-006 In S_IDLE, o_pulse SHALL be at the inactive level (~PULSE_POL) and o_busy SHALL be 0.
REQ-007 The block SHALL accept a start only in S_IDLE, and only when i_start=1, iv_pulse_width!=0 and iv_pulse_num!=0.
REQ-008 At the accepting edge, the block SHALL latch iv_pulse_width, iv_gap_width and iv_pulse_num, and SHALL enter S_PULSE.
REQ-009 The block SHALL ignore a start with a zero width or a zero count: no pulse, no o_busy, no o_done.
REQ-010 Timing convention: cycle n is the clk period following edge n. If a start is accepted at edge T, o_pulse SHALL be active in cycles T..T+W-1, where W is the latched width.
REQ-011 The block SHALL derive o_busy and o_pulse from the state and counter registers, with zero cycles of latency relative to the state.
REQ-012 In S_PULSE, the width counter SHALL count from 0. At count W-1 the FSM SHALL do one of the following:
- go to S_GAP if pulses remain;
- go to S_IDLE if this was the last pulse.
REQ-013 In S_GAP, o_pulse SHALL be inactive for G cycles, where G is the latched gap. A gap of G=0 SHALL be treated as G=1, so that every pulse has two detectable edges.
REQ-014 At the end of the gap, the FSM SHALL return to S_PULSE and SHALL decrement the remaining-pulse counter.
REQ-015 For a train of N pulses started at edge T, o_busy SHALL be high in cycles T .. T+N*W+(N-1)*G'-1, where G'=max(G,1).
REQ-016 For the same train, o_done SHALL be high for exactly one cycle, T+N*W+(N-1)*G'. In that cycle o_busy SHALL be 0 and o_pulse SHALL be inactive.
REQ-017 A start that is accepted in the same cycle as o_done is high SHALL be honoured, giving back-to-back trains with a one-cycle inactive gap.
REQ-018 The block SHALL ignore i_start while o_busy=1. Changes on iv_* while busy SHALL have no effect on the current train.
REQ-019 When i_stop=1 in S_PULSE or S_GAP, the next state SHALL be S_IDLE, o_pulse SHALL go inactive, o_done SHALL stay 0, and all counters SHALL clear.
REQ-020 i_stop SHALL take priority over i_start in the same cycle.
REQ-021 Counters SHALL NOT wrap. The maximum values (2^COUNT_WIDTH-1 for width and gap, 2^NUM_WIDTH-1 for count) SHALL produce exactly that many cycles or pulses.

Reset
REQ-022 While reset=1, regardless of clk, the block SHALL force:
- state to S_IDLE;
- o_pulse to ~PULSE_POL;
- o_busy and o_done to 0;
- all counters and latched fields to 0.
REQ-023 Reset asserted mid-train SHALL abort the train immediately, with no o_done.
REQ-024 After reset deasserts, the first start SHALL be accepted on the first clk edge with i_start=1.

Verification
REQ-025 Single pulse: PULSE_POL=1, W=5, N=1, start at edge 10 -> o_pulse high in cycles 10-14; o_done in cycle 15; o_busy in cycles 10-14.
REQ-026 Train: W=3, G=2, N=3, start at edge 0 -> o_pulse pattern 111 00 111 00 111; o_done in cycle 13; a pulse width checker in the bench measures 3 cycles for every pulse.
REQ-027 Edge values: G=0 with N=2 and W=1 -> pattern 1 0 1 and o_done in cycle 3. A start with W=0 or N=0 -> no activity. W=65535 -> exactly 65535 active cycles.
REQ-028 Low polarity: PULSE_POL=0, W=4 -> o_pulse idles high and is low for 4 cycles; after reset o_pulse=1.
REQ-029 Abort: i_stop in the 2nd cycle of the gap with W=4, G=4, N=3 -> o_pulse inactive, o_busy=0 on the next cycle, and no o_done. Async reset mid-pulse -> outputs reach their reset values before the next clk edge.
REQ-030 Back-to-back and ignored starts:
- i_start held high with W=2, N=1 -> trains repeat with pattern 11 0 11 0 ..., and o_done pulses every 3 cycles.
- i_start pulsed while busy -> ignored.

Source files
------------

// File: rtl/gen_pulse_train.sv
// gen_pulse_train: programmable pulse train generator.
// Emits N pulses of W cycles separated by gaps of max(G,1) cycles.
module gen_pulse_train #(
  parameter int PULSE_POL   = 1,
  parameter int COUNT_WIDTH = 16,
  parameter int NUM_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [COUNT_WIDTH-1:0] iv_pulse_width,
  input  logic [COUNT_WIDTH-1:0] iv_gap_width,
  input  logic [NUM_WIDTH-1:0]   iv_pulse_num,
  output logic                   o_pulse,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic P_ACT = (PULSE_POL != 0);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);
  localparam logic [NUM_WIDTH-1:0]   N_ONE = NUM_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] w_q, w_d;
  logic [COUNT_WIDTH-1:0] g_q, g_d;
  logic [NUM_WIDTH-1:0]   n_q, n_d;

  logic pulse_d;
  logic busy_d;
  logic done_d;

  logic start_ok;
  logic p_end;
  logic g_end;
  logic last;

  // A start needs a non-zero width and count; stop always wins.
  assign start_ok = i_start && !i_stop
                 && (iv_pulse_width != '0)
                 && (iv_pulse_num != '0);

  assign p_end = (cnt_q == w_q - C_ONE);
  assign g_end = (cnt_q == g_q - C_ONE);
  assign last  = (n_q == N_ONE);

  // State, counters, latched fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      g_q     <= '0;
      n_q     <= '0;
      o_pulse <= ~P_ACT;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      g_q     <= g_d;
      n_q     <= n_d;
      o_pulse <= pulse_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // Next-state logic; outputs follow the next state so they
  // line up with the state register with no extra latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    g_d     = g_q;
    n_d     = n_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          w_d     = iv_pulse_width;
          // Zero gap is stretched to one cycle so pulses stay separable.
          g_d     = (iv_gap_width == '0) ? C_ONE : iv_gap_width;
          n_d     = iv_pulse_num;
        end
      end

      S_PULSE: begin
        if (i_stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          w_d     = '0;
          g_d     = '0;
          n_d     = '0;
        end else if (p_end) begin
          cnt_d = '0;
          if (last) begin
            state_d = S_IDLE;
            n_d     = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end

      S_GAP: begin
        if (i_stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          w_d     = '0;
          g_d     = '0;
          n_d     = '0;
        end else if (g_end) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          n_d     = n_q - N_ONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        n_d     = '0;
      end
    endcase

    pulse_d = (state_d == S_PULSE) ? P_ACT : ~P_ACT;
    busy_d  = (state_d != S_IDLE);
  end

endmodule
